// File: rtl/track_sequencer_if.sv
// Command/status bundle between the game top level and the track sequencer.
// The host side drives start/stop/pause; the sequencer drives addressing, strobes and status.
interface track_sequencer_if #(
  parameter int ADDR_W = 7
);
  logic              start;
  logic              stop;
  logic              pause;
  logic [ADDR_W-1:0] ram_addr;
  logic              load_en;
  logic              shift_en;
  logic              tick;
  logic [1:0]        phase;
  logic              playing;
  logic              song_done;
  logic [15:0]       beat_count;

  modport master (
    output start, stop, pause,
    input  ram_addr, load_en, shift_en, tick, phase, playing, song_done, beat_count
  );

  modport slave (
    input  start, stop, pause,
    output ram_addr, load_en, shift_en, tick, phase, playing, song_done, beat_count
  );
endinterface

// File: rtl/track_sequencer.sv
// Game sequencer for the four-track note datapath: beat divider, pattern RAM address, shared load/shift strobes.
// Build option SONG_LOOP_EN: the song wraps back to pattern 0 forever instead of draining into DONE.
module track_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int ADDR_W   = 7,
  parameter int SONG_LEN = 128,
  parameter int RAM_LAT  = 1
) (
  input  logic             CLOCK_50,
  input  logic             RESET_GAME,
  track_sequencer_if.slave bus
);

  localparam int DIV_W   = $clog2(TICK_DIV);
  localparam int PRIME_W = $clog2(RAM_LAT + 2);

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(TICK_DIV - 1);
  localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(RAM_LAT);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(SONG_LEN - 1);
  localparam logic [ADDR_W-1:0]  PLAY_ADDR  = (SONG_LEN == 1) ? '0 : ADDR_W'(1);
  // Eight ticks push the last pattern out of both 4-bit shifters.
  localparam logic [2:0]         DRAIN_LAST = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_PLAY,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state,      state_d;
  logic [ADDR_W-1:0]  ram_addr,   ram_addr_d;
  logic [1:0]         phase,      phase_d;
  logic [15:0]        beat_count, beat_count_d;
  logic [DIV_W-1:0]   div_cnt,    div_cnt_d;
  logic [PRIME_W-1:0] prime_cnt,  prime_cnt_d;
  logic [2:0]         drain_cnt,  drain_cnt_d;

  logic load_en;
  logic shift_en;
  logic tick;

  // NOTE: reset is synchronous and sampled inside the clocked block, so it
  // simply wins over every next-state value computed below.
  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge CLOCK_50) begin
    if (RESET_GAME) begin
      state      <= S_IDLE;
      ram_addr   <= '0;
      phase      <= '0;
      beat_count <= '0;
      div_cnt    <= '0;
      prime_cnt  <= '0;
      drain_cnt  <= '0;
    end else begin
      state      <= state_d;
      ram_addr   <= ram_addr_d;
      phase      <= phase_d;
      beat_count <= beat_count_d;
      div_cnt    <= div_cnt_d;
      prime_cnt  <= prime_cnt_d;
      drain_cnt  <= drain_cnt_d;
    end
  end

  // NOTE: every variable gets a hold/idle default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state;
    ram_addr_d   = ram_addr;
    phase_d      = phase;
    beat_count_d = beat_count;
    div_cnt_d    = div_cnt;
    prime_cnt_d  = prime_cnt;
    drain_cnt_d  = drain_cnt;
    load_en      = 1'b0;
    shift_en     = 1'b0;
    tick         = 1'b0;

    if (bus.stop) begin
      state_d      = S_IDLE;
      ram_addr_d   = '0;
      phase_d      = '0;
      beat_count_d = '0;
      div_cnt_d    = '0;
      prime_cnt_d  = '0;
      drain_cnt_d  = '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_d      = S_PRIME;
            ram_addr_d   = '0;
            phase_d      = '0;
            beat_count_d = '0;
            div_cnt_d    = '0;
            prime_cnt_d  = '0;
            drain_cnt_d  = '0;
          end
        end

        // Address 0 is held until the RAM output is valid, then loaded once.
        S_PRIME: begin
          if (prime_cnt == PRIME_LAST) begin
            load_en     = 1'b1;
            prime_cnt_d = '0;
            div_cnt_d   = '0;
            drain_cnt_d = '0;
            ram_addr_d  = PLAY_ADDR;
`ifdef SONG_LOOP_EN
            state_d     = S_PLAY;
`else
            state_d     = (SONG_LEN == 1) ? S_DRAIN : S_PLAY;
`endif
          end else begin
            prime_cnt_d = prime_cnt + PRIME_W'(1);
          end
        end

        S_PLAY, S_DRAIN: begin
          if (!bus.pause) begin
            if (div_cnt == DIV_LAST) begin
              tick         = 1'b1;
              shift_en     = 1'b1;
              div_cnt_d    = '0;
              beat_count_d = beat_count + 16'd1;
              phase_d      = phase + 2'd1;

              // The next pattern is loaded as the current one shifts its last beat.
              if (state == S_PLAY && phase == 2'd3) begin
                load_en = 1'b1;
                if (ram_addr == LAST_ADDR) begin
`ifdef SONG_LOOP_EN
                  ram_addr_d  = '0;
`else
                  state_d     = S_DRAIN;
                  drain_cnt_d = '0;
`endif
                end else begin
                  ram_addr_d = ram_addr + ADDR_W'(1);
                end
              end

              if (state == S_DRAIN) begin
                if (drain_cnt == DRAIN_LAST) begin
                  state_d = S_DONE;
                end else begin
                  drain_cnt_d = drain_cnt + 3'd1;
                end
              end
            end else begin
              div_cnt_d = div_cnt + DIV_W'(1);
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.ram_addr   = ram_addr;
  assign bus.load_en    = load_en;
  assign bus.shift_en   = shift_en;
  assign bus.tick       = tick;
  assign bus.phase      = phase;
  assign bus.beat_count = beat_count;
  assign bus.playing    = (state == S_PRIME) || (state == S_PLAY) || (state == S_DRAIN);
  assign bus.song_done  = (state == S_DONE);

endmodule
